// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Emulates a 3x4 matrix keypad from the scanner's point of view. Key codes
//   arrive over a valid/ready handshake and are queued in a small FIFO. Each
//   key is then held for HOLD_CYCLES cycles, followed by a release gap of
//   GAP_CYCLES cycles. While a key is held, its column output follows its row
//   input combinationally.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   key_in[3:0]       key code: 0-9 digits, 10 = '*', 11 = '#'
//   key_valid         key_in valid
//   key_ready         FIFO can accept (not full)
//   B, G, F, D        scanner row drives (1/2/3, 4/5/6, 7/8/9, */0/#)
//   C, A, E           column returns    (1/4/7/*, 2/5/8/0, 3/6/9/#)
//   pressed           a key is currently held
//   busy              FSM active or FIFO non-empty
//   key_err           one-cycle pulse after an invalid code is consumed
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 500,
  parameter int unsigned DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       B,
  input  logic       G,
  input  logic       F,
  input  logic       D,
  output logic       C,
  output logic       A,
  output logic       E,
  output logic       pressed,
  output logic       busy,
  output logic       key_err
);

  localparam int unsigned MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  // FIFO storage and pointers
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  // FSM and key state
  state_e        state_q, state_d;
  logic [3:0]    cur_key_q, cur_key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_err_q;

  logic full;
  logic empty;
  logic accept;
  logic code_ok;
  logic push;
  logic pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign accept  = key_valid && !full;
  assign code_ok = (key_in <= 4'd11);
  assign push    = accept && code_ok;
  assign pop     = (state_q == IDLE) && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      key_err_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= key_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      // Codes 12-15 are swallowed by the handshake but only flagged.
      key_err_q <= accept && !code_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_key_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_key_q <= cur_key_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_key_d = cur_key_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          cur_key_d = mem_q[rd_ptr_q];
          cnt_d     = HOLD_LD;
          state_d   = PRESS;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          cur_key_d = '0;
          cnt_d     = GAP_LD;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Column path: only the held key's row matters, so extra high rows are
  // ignored and the column simply follows that one row.
  logic       row_hit;
  logic [2:0] col_sel;

  always_comb begin
    row_hit = 1'b0;
    col_sel = 3'b000;
    case (cur_key_q)
      4'd1, 4'd2, 4'd3:   row_hit = B;
      4'd4, 4'd5, 4'd6:   row_hit = G;
      4'd7, 4'd8, 4'd9:   row_hit = F;
      4'd0, 4'd10, 4'd11: row_hit = D;
      default:            row_hit = 1'b0;
    endcase
    case (cur_key_q)
      4'd1, 4'd4, 4'd7, 4'd10: col_sel = 3'b100;
      4'd2, 4'd5, 4'd8, 4'd0:  col_sel = 3'b010;
      4'd3, 4'd6, 4'd9, 4'd11: col_sel = 3'b001;
      default:                 col_sel = 3'b000;
    endcase
  end

  assign pressed   = (state_q == PRESS);
  assign {C, A, E} = (pressed && row_hit) ? col_sel : 3'b000;
  assign key_ready = !full;
  assign busy      = (state_q != IDLE) || !empty;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int HOLD  = 8;
  localparam int GAPC  = 4;
  localparam int DEPTH = 4;
  localparam int PERIOD_KEYS = HOLD + GAPC + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] rows;  // {B,G,F,D}
  logic       C, A, E;
  logic       pressed, busy, key_err;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .B        (rows[3]),
    .G        (rows[2]),
    .F        (rows[1]),
    .D        (rows[0]),
    .C        (C),
    .A        (A),
    .E        (E),
    .pressed  (pressed),
    .busy     (busy),
    .key_err  (key_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] sb[$];      // expected keys, in push order
  int         starts[$];  // cycle numbers at which presses began
  bit         scan_en = 1'b0;
  bit         mon_en  = 1'b0;
  bit         in_press = 1'b0;
  int         plen = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Physical keypad map: keys 1-9 laid out row-major, bottom row */0/#.
  function automatic logic [3:0] row_of(input logic [3:0] k);
    logic [3:0] r;
    if (k >= 4'd1 && k <= 4'd9) r = 4'b1000 >> ((k - 4'd1) / 3);
    else r = 4'b0001;
    return r;
  endfunction

  function automatic logic [2:0] col_of(input logic [3:0] k);
    logic [2:0] c;
    if (k >= 4'd1 && k <= 4'd9) c = 3'b100 >> ((k - 4'd1) % 3);
    else if (k == 4'd10) c = 3'b100;
    else if (k == 4'd0)  c = 3'b010;
    else c = 3'b001;
    return c;
  endfunction

  // Scanner + monitor: sample columns for the current rows, then advance rows.
  always @(negedge clk) begin
    logic [2:0] exp_cols;
    if (mon_en) begin
      exp_cols = 3'b000;
      if (pressed) begin
        if (!in_press) begin
          in_press = 1'b1;
          plen = 0;
          starts.push_back(cyc);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_press: pressed=1 at cycle %0d, required no press (queue empty)", cyc);
          end
        end
        plen++;
        if (sb.size() > 0 && (rows & row_of(sb[0])) != 4'b0000) exp_cols = col_of(sb[0]);
      end else if (in_press) begin
        in_press = 1'b0;
        checks++;
        if (plen != HOLD) begin
          errors++;
          $display("FAIL hold_length: got %0d cycles, required %0d", plen, HOLD);
        end
        if (sb.size() > 0) void'(sb.pop_front());
      end
      checks++;
      if ({C, A, E} !== exp_cols) begin
        errors++;
        $display("FAIL columns: rows=%b CAE=%b, required %b (cycle %0d)", rows, {C, A, E}, exp_cols, cyc);
      end
    end
    if (scan_en) rows = {rows[0], rows[3:1]};
  end

  task automatic push_key(input logic [3:0] k, output bit ok, output int stalls);
    logic rdy;
    ok = 1'b0;
    stalls = 0;
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    while (!ok && stalls < 500) begin
      rdy = key_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: key %0d not accepted, required handshake within 500 cycles", k);
    end else if (k <= 4'd11) begin
      sb.push_back(k);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0 || in_press) && n < 2000);
    checks++;
    if (busy || sb.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic wait_press();
    int n = 0;
    while (!pressed && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!pressed) begin
      errors++;
      $display("FAIL press_timeout: pressed=%b, required 1 within 200 cycles", pressed);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_in = '0;
    rows = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if ({pressed, busy, key_err, C, A, E, key_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_values: p/b/err/C/A/E/rdy=%b, required 0000001",
               {pressed, busy, key_err, C, A, E, key_ready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pressed, busy, key_err, C, A, E, key_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL post_reset_idle: p/b/err/C/A/E/rdy=%b, required 0000001",
               {pressed, busy, key_err, C, A, E, key_ready});
    end
    rows = 4'b1000;
    scan_en = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int st;
    push_key(4'd5, ok, st);
    key_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pressed !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency_t0: pressed=%b busy=%b, required pressed=0 busy=1", pressed, busy);
    end
    @(negedge clk);
    checks++;
    if (pressed !== 1'b1) begin
      errors++;
      $display("FAIL single_latency_t1: pressed=%b, required 1", pressed);
    end
    wait_idle();
  endtask

  task automatic test_full_map();
    bit ok;
    int st;
    logic [3:0] keys[12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                             4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};
    foreach (keys[i]) push_key(keys[i], ok, st);
    key_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    bit ok;
    int st[6];
    logic [3:0] keys[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    starts.delete();
    foreach (keys[i]) push_key(keys[i], ok, st[i]);
    key_valid = 1'b0;
    checks++;
    if (st[0] + st[1] + st[2] + st[3] + st[4] != 0 || st[5] == 0) begin
      errors++;
      $display("FAIL ready_drop: stalls=%0d,%0d,%0d,%0d,%0d,%0d, required 0,0,0,0,0,>0",
               st[0], st[1], st[2], st[3], st[4], st[5]);
    end
    wait_idle();
    checks++;
    if (starts.size() != 6) begin
      errors++;
      $display("FAIL press_count: got %0d presses, required 6", starts.size());
    end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != PERIOD_KEYS) begin
        errors++;
        $display("FAIL key_spacing: key %0d spacing %0d, required %0d", i, starts[i] - starts[i-1], PERIOD_KEYS);
      end
    end
  endtask

  task automatic test_invalid();
    bit ok;
    int st;
    push_key(4'd13, ok, st);
    key_valid = 1'b0;
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL invalid_handshake: stalls=%0d, required 0", st);
    end
    @(negedge clk);
    checks++;
    if (key_err !== 1'b1 || busy !== 1'b0 || pressed !== 1'b0) begin
      errors++;
      $display("FAIL invalid_err: key_err=%b busy=%b pressed=%b, required 1 0 0", key_err, busy, pressed);
    end
    @(negedge clk);
    checks++;
    if (key_err !== 1'b0 || busy !== 1'b0 || pressed !== 1'b0) begin
      errors++;
      $display("FAIL invalid_pulse_end: key_err=%b busy=%b pressed=%b, required 0 0 0", key_err, busy, pressed);
    end
    push_key(4'd3, ok, st);
    key_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_multi_rows();
    bit ok;
    int st;
    scan_en = 1'b0;
    rows = 4'b0000;
    push_key(4'd8, ok, st);
    key_valid = 1'b0;
    wait_press();
    @(negedge clk);
    #2 rows = 4'b0011;
    #1;
    checks++;
    if ({C, A, E} !== 3'b010) begin
      errors++;
      $display("FAIL multi_rows_FD: CAE=%b, required 010", {C, A, E});
    end
    @(negedge clk);
    #2 rows = 4'b0001;
    #1;
    checks++;
    if ({C, A, E} !== 3'b000) begin
      errors++;
      $display("FAIL multi_rows_D_only: CAE=%b, required 000", {C, A, E});
    end
    wait_idle();
    rows = 4'b1000;
    scan_en = 1'b1;
  endtask

  task automatic test_reset_mid_press();
    bit ok;
    int st;
    bit seen = 1'b0;
    scan_en = 1'b0;
    rows = 4'b1111;
    push_key(4'd2, ok, st);
    push_key(4'd4, ok, st);
    push_key(4'd6, ok, st);
    key_valid = 1'b0;
    wait_press();
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({C, A, E} !== 3'b010) begin
      errors++;
      $display("FAIL pre_reset_press: CAE=%b, required 010", {C, A, E});
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pressed, C, A, E, key_ready, busy} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_mid_press: p/C/A/E/rdy/busy=%b, required 000010",
               {pressed, C, A, E, key_ready, busy});
    end
    sb.delete();
    in_press = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (pressed || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL press_after_reset: activity seen=%b, required 0", seen);
    end
    rows = 4'b1000;
    scan_en = 1'b1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_full_map();
    test_backpressure();
    test_invalid();
    test_multi_rows();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Models the physical 3x4 keypad as seen from the scanning side: accepts key codes over a valid/ready handshake, queues them, and "presses" each one by driving the matching column high whenever the scanner drives that key's row. Each key is held for a fixed number of cycles, then released for a fixed gap. It replaces the real keypad in simulation and in hardware self-test, wired directly to the keypad scanner's row outputs and column inputs.

## Interface
- HOLD_CYCLES, 1000: cycles each key stays pressed (>= 1)
- GAP_CYCLES, 500: cycles of release between consecutive keys (>= 1)
- DEPTH, 4: key FIFO entries (power of 2, >= 2)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_in  input  4  key code: 0-9 digits, 10 = '*', 11 = '#'
- key_valid  input  1  key_in valid
- key_ready  output  1  FIFO can accept (= not full)
- B, G, F, D  input  1 each  row drives from scanner (B: 1/2/3, G: 4/5/6, F: 7/8/9, D: */0/#)
- C, A, E  output  1 each  column returns (C: 1/4/7/*, A: 2/5/8/0, E: 3/6/9/#)
- pressed  output  1  a key is currently held
- busy  output  1  FSM not IDLE or FIFO non-empty
- key_err  output  1  one-cycle pulse: invalid code consumed

## Operation
- Handshake: transfer when key_valid && key_ready at a rising edge. Codes 0-11 are enqueued. Codes 12-15 are consumed but not enqueued, and key_err pulses high for the next cycle.
- FIFO: DEPTH entries, in-order. key_ready = !full. Push and pop in the same cycle are allowed when not full, and the count is unchanged.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: if the FIFO is non-empty, pop into cur_key, load counter = HOLD_CYCLES-1, go to PRESS. Otherwise stay.
  - PRESS: pressed = 1. If counter == 0, clear cur_key, load counter = GAP_CYCLES-1, go to GAP. Otherwise decrement.
  - GAP: pressed = 0. If counter == 0, go to IDLE. Otherwise decrement.
- Column logic is combinational, from the row inputs and the registered cur_key/pressed. A column is 1 only when pressed = 1 and the row for cur_key is 1.
  - If several rows are high at once, each row contributes independently (OR).
  - If no key is held, or no row is high, C = A = E = 0.
- Counter width: clog2(max(HOLD_CYCLES, GAP_CYCLES)) bits. The counter never wraps; it is reloaded on every state entry.

## Timing
- Reset values: state IDLE, FIFO empty, cur_key 0, counter 0, pressed 0, busy 0, key_err 0, C = A = E = 0, key_ready 1.
- Reset asserted mid-PRESS: columns and pressed drop to 0 immediately (asynchronously), and queued keys are discarded.
- Latency: a key handshaken at edge t0 with the FSM IDLE and the FIFO empty is popped at edge t0+1. pressed is high from t0+1 through t0+1+HOLD_CYCLES.
- Key-to-key period with a backlog: HOLD_CYCLES + GAP_CYCLES + 1 cycles (1 IDLE cycle per key).
- Row-to-column path is zero-latency combinational, so the scanner sees its column in the same cycle it drives the row.
- busy falls in the first IDLE cycle with the FIFO empty.
- key_err is registered: high exactly one cycle, starting the edge after the invalid handshake.

## Test plan
- Single key: HOLD=8, GAP=4. Push 5; scanner cycles rows B,G,F,D. Required: A=1 only while G=1, for 8 cycles starting 1 cycle after the push. Scanner reports keyOut 5 with press=1. Then all columns 0.
- Full map: push 1-9, 10, 0, 11 in order. Required: each key produces the correct row/column pair (e.g. 10 -> C on D, 11 -> E on D, 0 -> A on D), and keys appear in push order.
- Backpressure: DEPTH=4, hold key_valid with 6 keys. Required: key_ready drops after 4 entries plus the first pop, no key is lost or duplicated, and spacing is exactly HOLD+GAP+1 cycles.
- Invalid code: push 13. Required: handshake completes, key_err=1 for one cycle, no press, busy stays 0. A following push of 3 presses E on row B.
- Multiple rows: key 8 held, drive F=1 and D=1 together. Required: A=1, C=E=0. Drive only D: A=0.
- Reset mid-press: assert rst_n=0 during PRESS with 2 keys queued. Required: C=A=E=0 and pressed=0 immediately, key_ready=1. After release, no press occurs.
